ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_* (from ID/EX)             operands, immediate, PC, rd and control
//   fwd_a, fwd_b, wb_fwd_data     forwarding selects and writeback value
//   mem_* (EX/MEM, registered)    result, store data, rd and control bits
//   redirect_valid, redirect_pc   combinational control-flow redirect
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1_data,
    input  logic [31:0] ex_rs2_data,
    input  logic [31:0] ex_imm,
    input  logic [4:0]  ex_rd,
    input  logic [3:0]  ex_alu_op,
    input  logic        ex_alu_src_a_pc,
    input  logic        ex_alu_src_b_imm,
    input  logic        ex_branch,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_memtoreg,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] wb_fwd_data,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_store_data,
    output logic [4:0]  mem_rd,
    output logic        mem_regwrite,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic        mem_memtoreg,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_store_data;
    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic            r_memread;
    logic            r_memwrite;
    logic            r_memtoreg;

    logic [XLEN-1:0] w_fa;
    logic [XLEN-1:0] w_fb;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_out;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_result;
    logic            w_taken;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jalr_target;

    // Forwarding muxes; 11 falls back to the register file. 10 reads the
    // EX/MEM register as it stood before this edge.
    always_comb begin
        w_fa = ex_rs1_data;
        case (fwd_a)
            2'b01:   w_fa = wb_fwd_data;
            2'b10:   w_fa = r_alu_result;
            default: w_fa = ex_rs1_data;
        endcase
    end

    always_comb begin
        w_fb = ex_rs2_data;
        case (fwd_b)
            2'b01:   w_fb = wb_fwd_data;
            2'b10:   w_fb = r_alu_result;
            default: w_fb = ex_rs2_data;
        endcase
    end

    assign w_alu_a = ex_alu_src_a_pc  ? ex_pc  : w_fa;
    assign w_alu_b = ex_alu_src_b_imm ? ex_imm : w_fb;
    assign w_shamt = w_alu_b[4:0];

    // ALU
    always_comb begin
        w_alu_out = '0;
        case (ex_alu_op)
            4'd0:    w_alu_out = w_alu_a + w_alu_b;
            4'd1:    w_alu_out = w_alu_a - w_alu_b;
            4'd2:    w_alu_out = w_alu_a << w_shamt;
            4'd3:    w_alu_out = XLEN'($signed(w_alu_a) < $signed(w_alu_b));
            4'd4:    w_alu_out = XLEN'(w_alu_a < w_alu_b);
            4'd5:    w_alu_out = w_alu_a ^ w_alu_b;
            4'd6:    w_alu_out = w_alu_a >> w_shamt;
            4'd7:    w_alu_out = XLEN'($signed(w_alu_a) >>> w_shamt);
            4'd8:    w_alu_out = w_alu_a | w_alu_b;
            4'd9:    w_alu_out = w_alu_a & w_alu_b;
            4'd10:   w_alu_out = w_alu_b;
            default: w_alu_out = '0;
        endcase
    end

    assign w_pc_plus4 = ex_pc + XLEN'(4);
    assign w_result   = (ex_jal || ex_jalr) ? w_pc_plus4 : w_alu_out;

    // Branch condition on forwarded operands; 010/011 never taken.
    always_comb begin
        w_taken = 1'b0;
        case (ex_funct3)
            3'b000:  w_taken = (w_fa == w_fb);
            3'b001:  w_taken = (w_fa != w_fb);
            3'b100:  w_taken = ($signed(w_fa) <  $signed(w_fb));
            3'b101:  w_taken = ($signed(w_fa) >= $signed(w_fb));
            3'b110:  w_taken = (w_fa <  w_fb);
            3'b111:  w_taken = (w_fa >= w_fb);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_br_target   = ex_pc + ex_imm;
    assign w_jalr_target = (w_fa + ex_imm) & ~XLEN'(1);

    assign redirect_valid = ex_valid & ~ex_stall & ~rst &
                            (ex_jal | ex_jalr | (ex_branch & w_taken));
    assign redirect_pc    = !redirect_valid ? '0 :
                            (ex_jalr ? w_jalr_target : w_br_target);

    // EX/MEM register: reset beats stall, stall beats load; bubbles clear all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
        end else if (!ex_stall) begin
            if (ex_valid) begin
                r_alu_result <= w_result;
                r_store_data <= w_fb;
                r_rd         <= ex_rd;
                r_regwrite   <= ex_regwrite;
                r_memread    <= ex_memread;
                r_memwrite   <= ex_memwrite;
                r_memtoreg   <= ex_memtoreg;
            end else begin
                r_alu_result <= '0;
                r_store_data <= '0;
                r_rd         <= '0;
                r_regwrite   <= 1'b0;
                r_memread    <= 1'b0;
                r_memwrite   <= 1'b0;
                r_memtoreg   <= 1'b0;
            end
        end
    end

    assign mem_alu_result = r_alu_result;
    assign mem_store_data = r_store_data;
    assign mem_rd         = r_rd;
    assign mem_regwrite   = r_regwrite;
    assign mem_memread    = r_memread;
    assign mem_memwrite   = r_memwrite;
    assign mem_memtoreg   = r_memtoreg;

endmodule
